// File: rtl/lb_initiator.sv
// Local-bus initiator: turns AXI4-stream register commands into single local-bus
// write/read strobes and returns read data (plus a timeout flag) on a response stream.
module lb_initiator #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                           cfgclk,
    input  logic                           cfgreset,
    input  logic [ADDR_WIDTH+DATA_WIDTH:0] cmd_tdata,
    input  logic                           cmd_tvalid,
    output logic                           cmd_tready,
    output logic [DATA_WIDTH:0]            rsp_tdata,
    output logic                           rsp_tvalid,
    input  logic                           rsp_tready,
    output logic                           lb_wr,
    output logic                           lb_rd,
    output logic [ADDR_WIDTH-1:0]          lb_addr,
    output logic [DATA_WIDTH-1:0]          lb_wdata,
    input  logic [DATA_WIDTH-1:0]          lb_rdata,
    input  logic                           lb_rdatavalid,
    output logic                           busy
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {IDLE, WRITE, RDREQ, RDWAIT, RESP} state_t;

    state_t                  state_q;
    logic [TW-1:0]           timer_q;
    logic                    cmd_tready_q;
    logic [DATA_WIDTH:0]     rsp_tdata_q;
    logic                    rsp_tvalid_q;
    logic                    lb_wr_q;
    logic                    lb_rd_q;
    logic [ADDR_WIDTH-1:0]   lb_addr_q;
    logic [DATA_WIDTH-1:0]   lb_wdata_q;
    logic                    busy_q;

    // Every output is a register, so strobes last exactly the one cycle spent in WRITE/RDREQ.
    always_ff @(posedge cfgclk or posedge cfgreset) begin
        if (cfgreset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            cmd_tready_q <= 1'b0;
            rsp_tdata_q  <= '0;
            rsp_tvalid_q <= 1'b0;
            lb_wr_q      <= 1'b0;
            lb_rd_q      <= 1'b0;
            lb_addr_q    <= '0;
            lb_wdata_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            lb_wr_q <= 1'b0;
            lb_rd_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cmd_tready_q <= 1'b1;
                    busy_q       <= 1'b0;
                    if (cmd_tvalid && cmd_tready_q) begin
                        cmd_tready_q <= 1'b0;
                        busy_q       <= 1'b1;
                        lb_addr_q    <= cmd_tdata[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
                        if (cmd_tdata[ADDR_WIDTH+DATA_WIDTH]) begin
                            state_q <= RDREQ;
                            lb_rd_q <= 1'b1;
                        end else begin
                            state_q    <= WRITE;
                            lb_wr_q    <= 1'b1;
                            lb_wdata_q <= cmd_tdata[DATA_WIDTH-1:0];
                        end
                    end
                end
                WRITE: begin
                    state_q      <= IDLE;
                    busy_q       <= 1'b0;
                    cmd_tready_q <= 1'b1;
                end
                RDREQ: begin
                    // Read data in the strobe cycle itself is never looked at here.
                    state_q <= RDWAIT;
                    timer_q <= '0;
                end
                RDWAIT: begin
                    if (lb_rdatavalid) begin
                        rsp_tdata_q  <= {1'b0, lb_rdata};
                        rsp_tvalid_q <= 1'b1;
                        state_q      <= RESP;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        rsp_tdata_q  <= {1'b1, {DATA_WIDTH{1'b0}}};
                        rsp_tvalid_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_tready) begin
                        rsp_tvalid_q <= 1'b0;
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                        cmd_tready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    busy_q       <= 1'b0;
                    rsp_tvalid_q <= 1'b0;
                    cmd_tready_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_tready = cmd_tready_q;
    assign rsp_tdata  = rsp_tdata_q;
    assign rsp_tvalid = rsp_tvalid_q;
    assign lb_wr      = lb_wr_q;
    assign lb_rd      = lb_rd_q;
    assign lb_addr    = lb_addr_q;
    assign lb_wdata   = lb_wdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_lb_initiator.sv
// Directed bench for lb_initiator: a table of write/read transactions with hand-computed
// responses, plus reset-in-flight and randomly gapped back-to-back sequences.
module tb_lb_initiator;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 64;

    logic            cfgclk = 1'b0;
    logic            cfgreset;
    logic [AW+DW:0]  cmd_tdata;
    logic            cmd_tvalid;
    logic            cmd_tready;
    logic [DW:0]     rsp_tdata;
    logic            rsp_tvalid;
    logic            rsp_tready;
    logic            lb_wr;
    logic            lb_rd;
    logic [AW-1:0]   lb_addr;
    logic [DW-1:0]   lb_wdata;
    logic [DW-1:0]   lb_rdata;
    logic            lb_rdatavalid;
    logic            busy;

    lb_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .cfgclk(cfgclk), .cfgreset(cfgreset),
        .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready),
        .rsp_tdata(rsp_tdata), .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready),
        .lb_wr(lb_wr), .lb_rd(lb_rd), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
        .lb_rdata(lb_rdata), .lb_rdatavalid(lb_rdatavalid), .busy(busy)
    );

    always #5 cfgclk = ~cfgclk;

    // lat: cycle after lb_rd where the slave answers (0 = silent); late: extra stale valid.
    typedef struct {
        bit          op;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        bit          same;
        int          hold;
        int          late;
        logic [32:0] expRsp;
    } vec_t;

    vec_t        vecs[8];
    int          checks = 0;
    int          errors = 0;
    int          beats  = 0;
    logic [31:0] lastWdata = '0;

    always @(posedge cfgclk) if (rsp_tvalid && rsp_tready) beats++;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge cfgclk);
    endtask

    task automatic issue(input bit op, input logic [15:0] addr, input logic [31:0] wdata);
        int k;
        k = 0;
        cmd_tdata  = {op, addr, wdata};
        cmd_tvalid = 1'b1;
        while (cmd_tready !== 1'b1 && k < 100) begin
            step();
            k++;
        end
        if (k == 100) checkOutput("cmd_tready_timeout", 64'(cmd_tready), 64'd1);
        step();
    endtask

    task automatic applyStimulus(input vec_t v);
        int b0;
        int expCycle;
        int endCycle;
        b0 = beats;
        issue(v.op, v.addr, v.wdata);
        if (!v.op) begin
            checkOutput("wr_strobe", 64'(lb_wr), 64'd1);
            checkOutput("wr_no_rd", 64'(lb_rd), 64'd0);
            checkOutput("wr_addr", 64'(lb_addr), 64'(v.addr));
            checkOutput("wr_data", 64'(lb_wdata), 64'(v.wdata));
            checkOutput("wr_tready_low", 64'(cmd_tready), 64'd0);
            checkOutput("wr_busy", 64'(busy), 64'd1);
            lastWdata = v.wdata;
            step();
            cmd_tvalid = 1'b0;
            checkOutput("wr_strobe_end", 64'(lb_wr), 64'd0);
            checkOutput("wr_tready_back", 64'(cmd_tready), 64'd1);
            checkOutput("wr_busy_end", 64'(busy), 64'd0);
            checkOutput("wr_no_rsp", 64'(rsp_tvalid), 64'd0);
            checkOutput("wr_no_beat", 64'(beats), 64'(b0));
        end else begin
            cmd_tvalid = 1'b0;
            expCycle = (v.lat >= 1 && v.lat <= TO) ? v.lat + 1 : TO + 1;
            endCycle = expCycle + v.hold + 2;
            if (v.late + 2 > endCycle) endCycle = v.late + 2;
            for (int c = 0; c <= endCycle; c++) begin
                rsp_tready    = (c >= expCycle + v.hold);
                lb_rdatavalid = (c == v.lat && c > 0) || (c == v.late && v.late > 0) || (c == 0 && v.same);
                lb_rdata      = (c == v.lat && c > 0) ? v.rdata : 32'hDEAD_BEEF;
                if (c == 0) begin
                    checkOutput("rd_strobe", 64'(lb_rd), 64'd1);
                    checkOutput("rd_no_wr", 64'(lb_wr), 64'd0);
                    checkOutput("rd_addr", 64'(lb_addr), 64'(v.addr));
                    checkOutput("rd_wdata_hold", 64'(lb_wdata), 64'(lastWdata));
                end else if (c < expCycle) begin
                    checkOutput("rd_wait_no_rsp", 64'(rsp_tvalid), 64'd0);
                    checkOutput("rd_strobe_once", 64'(lb_rd), 64'd0);
                end else if (c <= expCycle + v.hold) begin
                    checkOutput("rsp_valid", 64'(rsp_tvalid), 64'd1);
                    checkOutput("rsp_data", 64'(rsp_tdata), 64'(v.expRsp));
                    checkOutput("rsp_blocks_cmd", 64'(cmd_tready), 64'd0);
                end else begin
                    checkOutput("rsp_done", 64'(rsp_tvalid), 64'd0);
                    if (c == expCycle + v.hold + 1) begin
                        checkOutput("rd_tready_back", 64'(cmd_tready), 64'd1);
                        checkOutput("rd_busy_end", 64'(busy), 64'd0);
                    end
                end
                step();
            end
            lb_rdatavalid = 1'b0;
            rsp_tready    = 1'b0;
            checkOutput("rd_one_beat", 64'(beats), 64'(b0 + 1));
        end
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{1'b0, 16'h0010, 32'hA5A5_0001, 0,  32'h0,         1'b0, 0,  0,  33'h0};
        vecs[1] = '{1'b1, 16'h0020, 32'h0,         3,  32'h1234_5678, 1'b0, 0,  0,  33'h0_1234_5678};
        vecs[2] = '{1'b1, 16'h0030, 32'h0,         0,  32'h0,         1'b0, 0,  70, 33'h1_0000_0000};
        vecs[3] = '{1'b1, 16'h0040, 32'h0,         1,  32'hCAFE_F00D, 1'b0, 20, 0,  33'h0_CAFE_F00D};
        vecs[4] = '{1'b1, 16'h0050, 32'h0,         64, 32'h0BAD_BEEF, 1'b0, 0,  0,  33'h0_0BAD_BEEF};
        vecs[5] = '{1'b1, 16'h0060, 32'h0,         2,  32'h55AA_55AA, 1'b1, 0,  0,  33'h0_55AA_55AA};
        vecs[6] = '{1'b0, 16'hFFFF, 32'hFFFF_FFFF, 0,  32'h0,         1'b0, 0,  0,  33'h0};
        vecs[7] = '{1'b1, 16'h0070, 32'h0,         65, 32'h7777_7777, 1'b0, 2,  0,  33'h1_0000_0000};

        cfgreset      = 1'b1;
        cmd_tdata     = '0;
        cmd_tvalid    = 1'b0;
        rsp_tready    = 1'b0;
        lb_rdata      = '0;
        lb_rdatavalid = 1'b0;
        step();
        step();
        checkOutput("rst_cmd_tready", 64'(cmd_tready), 64'd0);
        checkOutput("rst_rsp_tvalid", 64'(rsp_tvalid), 64'd0);
        checkOutput("rst_strobes", 64'({lb_wr, lb_rd}), 64'd0);
        checkOutput("rst_addr_data", 64'({lb_addr, lb_wdata}), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        cfgreset = 1'b0;
        step();
        checkOutput("idle_tready", 64'(cmd_tready), 64'd1);

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        // Reset while waiting for read data: everything drops at once, stale reply ignored.
        issue(1'b1, 16'h0abc, 32'h0);
        cmd_tvalid = 1'b0;
        step();
        step();
        step();
        cfgreset = 1'b1;
        #1;
        checkOutput("midrst_strobes", 64'({lb_wr, lb_rd}), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_tready", 64'(cmd_tready), 64'd0);
        checkOutput("midrst_rsp", 64'({rsp_tvalid, rsp_tdata}), 64'd0);
        checkOutput("midrst_addr", 64'({lb_addr, lb_wdata}), 64'd0);
        lastWdata = '0;
        step();
        cfgreset      = 1'b0;
        lb_rdatavalid = 1'b1;
        lb_rdata      = 32'h0BAD_0BAD;
        step();
        lb_rdatavalid = 1'b0;
        step();
        checkOutput("postrst_no_rsp", 64'(rsp_tvalid), 64'd0);
        checkOutput("postrst_tready", 64'(cmd_tready), 64'd1);
        applyStimulus('{1'b1, 16'h0abc, 32'h0, 2, 32'h600D_DA7A, 1'b0, 0, 0, 33'h0_600D_DA7A});

        // Back-to-back writes then reads with random command gaps, latencies and backpressure.
        for (int i = 0; i < 16; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) step();
            v.op     = (i >= 8);
            v.addr   = 16'h0100 + 16'(i);
            v.wdata  = $urandom;
            v.lat    = int'($urandom_range(1, 5));
            v.rdata  = $urandom;
            v.same   = 1'b0;
            v.hold   = int'($urandom_range(0, 3));
            v.late   = 0;
            v.expRsp = {1'b0, v.rdata};
            applyStimulus(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
